// File: rtl/uart_rx_if.sv
// uart_rx_if -- handshake/bus bundle for the UART receiver.
//   baudX7   : one-clk tick at 7x bit rate (driven by master)
//   rxd      : raw serial line, idle high (driven by master)
//   clear    : one-clk pulse clearing the sticky flags (driven by master)
//   rxData   : last correctly framed byte (driven by receiver)
//   rxReady  : sticky byte-available flag
//   frameErr : sticky flag, stop bit sampled low
//   overrun  : sticky flag, byte completed while rxReady already set
`timescale 1ns/1ps
interface uart_rx_if;
  logic       baudX7;
  logic       rxd;
  logic       clear;
  logic [7:0] rxData;
  logic       rxReady;
  logic       frameErr;
  logic       overrun;

  modport master (output baudX7, rxd, clear,
                  input  rxData, rxReady, frameErr, overrun);
  modport slave  (input  baudX7, rxd, clear,
                  output rxData, rxReady, frameErr, overrun);
endinterface

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver with 7x oversampling and sticky status flags.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : uart_rx_if.slave (baudX7, rxd, clear in; rxData, rxReady,
//           frameErr, overrun out)
// Parameter MIDPHASE (0..6): oversample phase at which each bit is sampled.
// Optional macro UART_RX_MAJORITY_EN: each bit is the 2-of-3 vote of the
// phases around MIDPHASE, decided one tick after MIDPHASE.
`timescale 1ns/1ps
module uart_rx #(
  parameter int MIDPHASE = 3
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  localparam logic [2:0] P_SAMP = 3'(MIDPHASE);

  // rxd is asynchronous; two flops before anything looks at it
  logic sync1_q, rxs_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= bus.rxd;
      rxs_q   <= sync1_q;
    end
  end

  logic [2:0] state_q, state_d;
  logic [2:0] phase_q, phase_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       rdy_q, rdy_d;
  logic       ferr_q, ferr_d;
  logic       ovr_q, ovr_d;

  logic [2:0] phase_inc;
  logic       in_frame;
  logic       samp;
  logic       bit_val;

  // phase counts 0..6 only
  assign phase_inc = (phase_q == 3'd6) ? 3'd0 : phase_q + 3'd1;
  assign in_frame  = (state_q == S_START) || (state_q == S_DATA) ||
                     (state_q == S_STOP);

`ifdef UART_RX_MAJORITY_EN
  localparam logic [2:0] P_PRE = 3'((MIDPHASE + 6) % 7);
  localparam logic [2:0] P_DEC = 3'((MIDPHASE + 1) % 7);

  // votes captured at MIDPHASE-1 and MIDPHASE; third vote is the live rxs
  logic v0_q, v1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
    end else if (bus.baudX7 && in_frame) begin
      if (phase_inc == P_PRE)  v0_q <= rxs_q;
      if (phase_inc == P_SAMP) v1_q <= rxs_q;
    end
  end

  assign samp    = (phase_inc == P_DEC);
  assign bit_val = (v0_q & v1_q) | (v0_q & rxs_q) | (v1_q & rxs_q);
`else
  assign samp    = (phase_inc == P_SAMP);
  assign bit_val = rxs_q;
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    rdy_d   = rdy_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;

    // clear first so a same-cycle set below takes priority
    if (bus.clear) begin
      rdy_d  = 1'b0;
      ferr_d = 1'b0;
      ovr_d  = 1'b0;
    end

    if (bus.baudX7) begin
      case (state_q)
        S_IDLE: begin
          if (!rxs_q) begin
            state_d = S_START;
            phase_d = 3'd0;
          end
        end
        S_START, S_DATA, S_STOP: begin
          phase_d = phase_inc;
          if (samp) begin
            case (state_q)
              S_START: begin
                if (!bit_val) begin
                  state_d = S_DATA;
                  bit_d   = 3'd0;
                end else begin
                  state_d = S_IDLE;  // false start
                end
              end
              S_DATA: begin
                shift_d = {bit_val, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = S_STOP;
              end
              S_STOP: begin
                if (bit_val) begin
                  data_d  = shift_q;
                  rdy_d   = 1'b1;
                  // a clear in this cycle consumes the old byte: no overrun
                  if (rdy_q && !bus.clear) ovr_d = 1'b1;
                  state_d = S_IDLE;
                end else begin
                  ferr_d  = 1'b1;
                  state_d = S_BREAK;
                end
              end
              default: ;
            endcase
          end
        end
        S_BREAK: begin
          // wait for the line to return high; a low line never restarts here
          if (rxs_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= 3'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.rxData   = data_q;
  assign bus.rxReady  = rdy_q;
  assign bus.frameErr = ferr_q;
  assign bus.overrun  = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- self-checking bench for uart_rx (MIDPHASE=3, tick every 4 clk).
`timescale 1ns/1ps
module tb_uart_rx;

  logic clk = 1'b0;
  logic reset = 1'b1;
  uart_rx_if bus();

  uart_rx #(.MIDPHASE(3)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #20 clk = ~clk;

`ifdef UART_RX_MAJORITY_EN
  localparam int         LAT      = 1;
  localparam logic [7:0] GLITCH_D = 8'h00;
`else
  localparam int         LAT      = 0;
  localparam logic [7:0] GLITCH_D = 8'h04;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       r;
    logic       f;
    logic       o;
  } obs_t;

  obs_t sb[$];
  obs_t exp_v;
  int   checks = 0;
  int   errors = 0;

  function automatic obs_t observe();
    return obs_t'{bus.rxData, bus.rxReady, bus.frameErr, bus.overrun};
  endfunction

  // 7x baud tick: one clk wide, every 4 clk
  initial begin
    bus.baudX7 = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      bus.baudX7 = 1'b1;
      @(negedge clk);
      bus.baudX7 = 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // returns 1 ns after the n-th tick edge
  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (bus.baudX7 !== 1'b1);
    end
    #1;
  endtask

  // returns 1 ns after the negedge that opens the next tick cycle
  task automatic wait_tick_cycle();
    do begin
      @(negedge clk);
      #1;
    end while (bus.baudX7 !== 1'b1);
  endtask

  task automatic idle(input int n);
    bus.rxd = 1'b1;
    wait_ticks(n);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  // must be entered right after a tick edge; leaves the line at the stop value
  task automatic send_frame(input logic [7:0] b, input logic stopb, input int glitch);
    bus.rxd = 1'b0;
    wait_ticks(7);
    for (int k = 0; k < 8; k++) begin
      bus.rxd = b[k];
      if (k == glitch) begin
        wait_ticks(3);
        bus.rxd = 1'b1;
        wait_ticks(1);
        bus.rxd = b[k];
        wait_ticks(3);
      end else begin
        wait_ticks(7);
      end
    end
    bus.rxd = stopb;
    wait_ticks(7);
  endtask

  task automatic test_reset();
    bus.rxd   = 1'b1;
    bus.clear = 1'b0;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (observe() !== obs_t'(11'h0)) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", observe(), obs_t'(11'h0));
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    idle(7);
    sb.push_back(obs_t'{8'h55, 1'b1, 1'b0, 1'b0});
    fork
      send_frame(8'h55, 1'b1, -1);
      begin
        wait_ticks(66 + LAT);
        wait_tick_cycle();
        checks++;
        if (bus.rxReady !== 1'b0) begin
          errors++;
          $display("FAIL basic_early_ready: got %b expected 0", bus.rxReady);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.rxReady !== 1'b1) begin
          errors++;
          $display("FAIL basic_latency_ready: got %b expected 1", bus.rxReady);
        end
      end
    join
    exp_v = sb.pop_front();
    checks++;
    if (observe() !== exp_v) begin
      errors++;
      $display("FAIL basic_0x55: got %h expected %h", observe(), exp_v);
    end
    pulse_clear();
    #1;
    checks++;
    if (observe() !== obs_t'{8'h55, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL clear_keeps_data: got %h expected %h", observe(),
               obs_t'{8'h55, 1'b0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_false_start();
    idle(7);
    bus.rxd = 1'b0;
    wait_ticks(2);
    idle(14);
    checks++;
    if (observe() !== obs_t'{8'h55, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL false_start_flags: got %h expected %h", observe(),
               obs_t'{8'h55, 1'b0, 1'b0, 1'b0});
    end
    sb.push_back(obs_t'{8'hA3, 1'b1, 1'b0, 1'b0});
    send_frame(8'hA3, 1'b1, -1);
    exp_v = sb.pop_front();
    checks++;
    if (observe() !== exp_v) begin
      errors++;
      $display("FAIL after_false_start_0xA3: got %h expected %h", observe(), exp_v);
    end
  endtask

  task automatic test_break();
    pulse_clear();
    idle(7);
    sb.push_back(obs_t'{8'hA3, 1'b0, 1'b1, 1'b0});
    send_frame(8'h0F, 1'b0, -1);
    exp_v = sb.pop_front();
    checks++;
    if (observe() !== exp_v) begin
      errors++;
      $display("FAIL frame_error: got %h expected %h", observe(), exp_v);
    end
    wait_ticks(20);
    checks++;
    if (observe() !== exp_v) begin
      errors++;
      $display("FAIL break_hold: got %h expected %h", observe(), exp_v);
    end
    idle(7);
    sb.push_back(obs_t'{8'h0F, 1'b1, 1'b1, 1'b0});
    send_frame(8'h0F, 1'b1, -1);
    exp_v = sb.pop_front();
    checks++;
    if (observe() !== exp_v) begin
      errors++;
      $display("FAIL after_break_0x0F: got %h expected %h", observe(), exp_v);
    end
  endtask

  task automatic test_overrun();
    pulse_clear();
    idle(7);
    sb.push_back(obs_t'{8'h12, 1'b1, 1'b0, 1'b0});
    sb.push_back(obs_t'{8'h34, 1'b1, 1'b0, 1'b1});
    send_frame(8'h12, 1'b1, -1);
    exp_v = sb.pop_front();
    checks++;
    if (observe() !== exp_v) begin
      errors++;
      $display("FAIL first_0x12: got %h expected %h", observe(), exp_v);
    end
    idle(7);
    send_frame(8'h34, 1'b1, -1);
    exp_v = sb.pop_front();
    checks++;
    if (observe() !== exp_v) begin
      errors++;
      $display("FAIL overrun_0x34: got %h expected %h", observe(), exp_v);
    end
    pulse_clear();
    #1;
    checks++;
    if (observe() !== obs_t'{8'h34, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL clear_all: got %h expected %h", observe(),
               obs_t'{8'h34, 1'b0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_clear_race();
    idle(7);
    sb.push_back(obs_t'{8'h56, 1'b1, 1'b0, 1'b0});
    sb.push_back(obs_t'{8'h77, 1'b1, 1'b0, 1'b0});
    send_frame(8'h56, 1'b1, -1);
    exp_v = sb.pop_front();
    checks++;
    if (observe() !== exp_v) begin
      errors++;
      $display("FAIL pre_race_0x56: got %h expected %h", observe(), exp_v);
    end
    idle(7);
    fork
      send_frame(8'h77, 1'b1, -1);
      begin
        wait_ticks(66 + LAT);
        wait_tick_cycle();
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
      end
    join
    exp_v = sb.pop_front();
    checks++;
    if (observe() !== exp_v) begin
      errors++;
      $display("FAIL clear_race_0x77: got %h expected %h", observe(), exp_v);
    end
  endtask

  task automatic test_glitch();
    pulse_clear();
    idle(7);
    sb.push_back(obs_t'{GLITCH_D, 1'b1, 1'b0, 1'b0});
    send_frame(8'h00, 1'b1, 2);
    exp_v = sb.pop_front();
    checks++;
    if (observe() !== exp_v) begin
      errors++;
      $display("FAIL glitch_bit2: got %h expected %h", observe(), exp_v);
    end
  endtask

  task automatic test_reset_midframe();
    pulse_clear();
    idle(7);
    bus.rxd = 1'b0;
    wait_ticks(30);
    @(negedge clk);
    reset   = 1'b1;
    bus.rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (observe() !== obs_t'(11'h0)) begin
      errors++;
      $display("FAIL reset_midframe: got %h expected %h", observe(), obs_t'(11'h0));
    end
    @(negedge clk);
    reset = 1'b0;
    idle(80);
    checks++;
    if (observe() !== obs_t'(11'h0)) begin
      errors++;
      $display("FAIL post_reset_idle: got %h expected %h", observe(), obs_t'(11'h0));
    end
    sb.push_back(obs_t'{8'hA5, 1'b1, 1'b0, 1'b0});
    send_frame(8'hA5, 1'b1, -1);
    exp_v = sb.pop_front();
    checks++;
    if (observe() !== exp_v) begin
      errors++;
      $display("FAIL post_reset_0xA5: got %h expected %h", observe(), exp_v);
    end
  endtask

  initial begin
    bus.rxd   = 1'b1;
    bus.clear = 1'b0;
    test_reset();
    test_basic();
    test_false_start();
    test_break();
    test_overrun();
    test_clear_race();
    test_glitch();
    test_reset_midframe();
    idle(7);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter MIDPHASE, default 3, oversample phase (0..6) at which each bit is sampled.
REQ-002 clk  input  1  system clock (25 MHz); all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 baudX7  input  1  one-clk-wide tick at 7x the bit rate; only cycles with baudX7=1 advance the receiver.
REQ-005 rxd  input  1  serial line, idle high, asynchronous to clk.
REQ-006 clear  input  1  one-clk pulse; clears rxReady, frameErr and overrun.
REQ-007 rxData  output  8  last correctly framed byte.
REQ-008 rxReady  output  1  sticky flag, byte available (PDP-8 keyboard flag).
REQ-009 frameErr  output  1  sticky flag, stop bit sampled low.
REQ-010 overrun  output  1  sticky flag, byte completed while rxReady already set.

Function
REQ-011 rxd SHALL pass a 2-flop synchronizer; all logic uses the synchronized value rxs.
REQ-012 Frame format SHALL be 1 start, 8 data (LSB first), 1 stop, no parity.
REQ-013 The FSM SHALL have the states IDLE, START, DATA, STOP and BREAK; only these states.
REQ-014 IDLE: on a tick with rxs=0, go to START and set phase counter to 0.
REQ-015 In START, DATA and STOP, every tick SHALL advance the 3-bit phase counter, wrapping from 6 to 0; it SHALL never hold 7.
REQ-016 Sample tick = tick on which phase becomes MIDPHASE: 3 ticks after detection for start, then every 7 ticks.
REQ-017 START sample: rxs=0 -> DATA with bit index 0; rxs=1 -> false start, back to IDLE with no flag change.
REQ-018 DATA: each sample tick shifts rxs into the MSB of an 8-bit shift register; after bit index 7 -> STOP.
REQ-019 STOP sample rxs=1: load rxData from the shift register, set rxReady, set overrun if rxReady was already 1, go to IDLE.
REQ-020 STOP sample rxs=0: set frameErr, leave rxData and rxReady unchanged, go to BREAK.
REQ-021 BREAK: stay until a tick with rxs=1, then go to IDLE; a low line SHALL never start a new frame from BREAK.
REQ-022 Flag updates SHALL be visible in the clk cycle after the stop sample tick (1-clk latency).
REQ-023 clear in the same cycle as a flag set: set wins, rxReady=1; overrun SHALL NOT be set by that completion.
REQ-024 clear SHALL NOT affect FSM state, phase, shift register or rxData.
REQ-025 clk cycles with baudX7=0 SHALL change nothing except the synchronizer and clear-driven flags.

Reset
REQ-026 Reset SHALL force: state IDLE, phase 0, bit index 0, shift register 0x00, rxData 0x00, rxReady 0, frameErr 0, overrun 0, synchronizer flops 1.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no flag set; reception restarts only on a fresh falling edge after release.

Configuration
REQ-028 Macro UART_RX_MAJORITY_EN.
REQ-029 Macro defined: each bit value is the 2-of-3 majority of rxs at phases MIDPHASE-1, MIDPHASE and MIDPHASE+1; the decision is taken on the MIDPHASE+1 tick, so all sample points are one tick later than in REQ-016.
REQ-030 Macro undefined: single sample at MIDPHASE per REQ-016; no vote registers are instantiated.

Verification
REQ-031 0x55 frame, 7 ticks/bit, line idle before and after -> rxData=0x55, rxReady=1, frameErr=0, overrun=0, one clk after the stop sample tick.
REQ-032 rxd low for only 2 ticks, then high -> FSM returns to IDLE; rxReady stays 0; a following 0xA3 frame is received correctly.
REQ-033 Frame 0x0F with stop bit 0, line held low 20 ticks, then high -> frameErr=1, rxReady=0, rxData unchanged; no frame detected while low; next 0x0F frame is received correctly.
REQ-034 Frames 0x12 then 0x34, no clear in between -> rxData=0x34, rxReady=1, overrun=1; a clear pulse then gives all three flags 0.
REQ-035 clear pulsed in the exact cycle rxReady is set by 0x77 -> rxReady=1, overrun=0.
REQ-036 With UART_RX_MAJORITY_EN, a one-tick high glitch at the centre of data bit 2 of 0x00 -> rxData=0x00; without the macro -> rxData=0x04.
